reg_dump_reader: RTL

- Debug read-out engine on the read side of the processor register file.
- On request, asks the core to stall and waits for acknowledgement.
- Walks every register index through the file's combinational read port and streams each value out on a valid/ready interface.
- Sits between the register file read port and the debug/trace link; lets the bench or a host dump architectural state without touching the datapath.

---
 rtl/reg_dump_reader.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/reg_dump_reader.sv
// Debug read-out engine: halts the core, walks every register through the
// register file read port and streams each value over a valid/ready link.
module reg_dump_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 8,
    parameter int IDX_WIDTH  = 3
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  Start,
    input  logic                  Abort,
    input  logic                  Stall_Ack,
    input  logic [DATA_WIDTH-1:0] Read_Data,
    output logic [IDX_WIDTH-1:0]  Read_Reg_Num,
    output logic                  Stall_Req,
    output logic [DATA_WIDTH-1:0] Out_Data,
    output logic [IDX_WIDTH-1:0]  Out_Index,
    output logic                  Out_Last,
    output logic                  Out_Valid,
    input  logic                  Out_Ready,
    output logic                  Busy,
    output logic                  Done
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_ACK = 3'd1,
        READ     = 3'd2,
        SEND     = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_REGS - 1);
    localparam logic [IDX_WIDTH-1:0] ZERO_IDX = IDX_WIDTH'(0);

    state_t                  state_r;
    state_t                  state_next_s;
    logic [IDX_WIDTH-1:0]    index_r;
    logic [IDX_WIDTH-1:0]    index_next_s;
    logic [IDX_WIDTH-1:0]    read_reg_num_r;
    logic [DATA_WIDTH-1:0]   out_data_r;
    logic [IDX_WIDTH-1:0]    out_index_r;
    logic                    out_last_r;
    logic                    out_valid_r;
    logic                    stall_req_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    handshake_s;

    assign handshake_s = out_valid_r & Out_Ready;

    // Next-state and index sequencing; Abort always returns to IDLE with index 0.
    always_comb begin
        state_next_s = state_r;
        index_next_s = index_r;
        case (state_r)
            IDLE: begin
                if (Start && !Abort) begin
                    state_next_s = WAIT_ACK;
                    index_next_s = ZERO_IDX;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT_ACK: begin
                if (Abort) begin
                    state_next_s = IDLE;
                    index_next_s = ZERO_IDX;
                end else if (Stall_Ack) begin
                    state_next_s = READ;
                end else begin
                    state_next_s = WAIT_ACK;
                end
            end
            READ: begin
                if (Abort) begin
                    state_next_s = IDLE;
                    index_next_s = ZERO_IDX;
                end else begin
                    state_next_s = SEND;
                end
            end
            SEND: begin
                if (Abort) begin
                    state_next_s = IDLE;
                    index_next_s = ZERO_IDX;
                end else if (handshake_s && out_last_r) begin
                    state_next_s = DONE;
                end else if (handshake_s) begin
                    state_next_s = READ;
                    index_next_s = index_r + IDX_WIDTH'(1);
                end else begin
                    state_next_s = SEND;
                end
            end
            DONE: begin
                state_next_s = IDLE;
                index_next_s = ZERO_IDX;
            end
            default: begin
                state_next_s = IDLE;
                index_next_s = ZERO_IDX;
            end
        endcase
    end

    // State, index and registered outputs (all derived from the next state).
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r        <= IDLE;
            index_r        <= ZERO_IDX;
            read_reg_num_r <= ZERO_IDX;
            out_data_r     <= {DATA_WIDTH{1'b0}};
            out_index_r    <= ZERO_IDX;
            out_last_r     <= 1'b0;
            out_valid_r    <= 1'b0;
            stall_req_r    <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            index_r     <= index_next_s;
            stall_req_r <= (state_next_s != IDLE);
            busy_r      <= (state_next_s != IDLE);
            done_r      <= (state_next_s == DONE);
            if (state_next_s == READ) begin
                read_reg_num_r <= index_next_s;
            end else begin
                read_reg_num_r <= read_reg_num_r;
            end
            // Capture happens only on the READ->SEND transition; the beat then holds until accepted.
            if ((state_r == READ) && (state_next_s == SEND)) begin
                out_data_r  <= Read_Data;
                out_index_r <= index_r;
                out_last_r  <= (index_r == LAST_IDX);
                out_valid_r <= 1'b1;
            end else if (state_r == SEND && (handshake_s || Abort)) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

    assign Read_Reg_Num = read_reg_num_r;
    assign Stall_Req    = stall_req_r;
    assign Out_Data     = out_data_r;
    assign Out_Index    = out_index_r;
    assign Out_Last     = out_last_r;
    assign Out_Valid    = out_valid_r;
    assign Busy         = busy_r;
    assign Done         = done_r;

endmodule
